ddr2_traffic_checker: RTL and testbench



---
 rtl/ddr2_tc_pkg.sv | 28 ++
 rtl/ddr2_pat_gen.sv | 73 +++++++
 rtl/ddr2_traffic_checker.sv | 220 ++++++++++++++++++++++
 tb/tb_ddr2_traffic_checker.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_tc_pkg.sv
// Shared definitions for the DDR2 traffic checker: FSM state encoding, data
// pattern selectors and the PRBS-31 (x^31 + x^28 + 1) generator constants.
package ddr2_tc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StGap,
        StRead,
        StDrain,
        StDone
    } tc_state_e;

    localparam logic [1:0] ModeInc  = 2'd0;
    localparam logic [1:0] ModePrbs = 2'd1;
    localparam logic [1:0] ModeWalk = 2'd2;
    localparam logic [1:0] ModeInv  = 2'd3;

    localparam logic [30:0]  PrbsSeed  = 31'h1;
    localparam int unsigned  PrbsTapHi = 30;
    localparam int unsigned  PrbsTapLo = 27;

    // Feedback bit of one LFSR step; the state shifts left and takes this bit in.
    function automatic logic prbs_fb(input logic [30:0] s);
        return s[PrbsTapHi] ^ s[PrbsTapLo];
    endfunction

endpackage

// File: rtl/ddr2_pat_gen.sv
// Pattern generator for one word stream (write data or expected read data).
// Ports:
//   clk, rst  clock / asynchronous active-high reset
//   mode      pattern select (increment, PRBS-31, walking-one, ~index)
//   load      full re-seed: index 0, walking bit 0, LFSR back to seed
//   restart   index and walking bit back to 0, LFSR keeps running
//   advance   step to the next word
//   data      pattern word for the current index
module ddr2_pat_gen
    import ddr2_tc_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              load,
    input  logic              restart,
    input  logic              advance,
    output logic [DATA_W-1:0] data
);

    logic [15:0]       idx;
    logic [DATA_W-1:0] walk;
    logic [30:0]       lfsr;
    logic [30:0]       lfsr_next;
    logic [DATA_W-1:0] prbs_word;

    // Parallel PRBS: DATA_W serial steps unrolled; bit k of the word is the
    // k-th generated bit.
    always_comb begin : prbs_calc
        logic [30:0] s;
        s         = lfsr;
        prbs_word = '0;
        for (int k = 0; k < DATA_W; k++) begin
            prbs_word[k] = prbs_fb(s);
            s            = {s[29:0], prbs_word[k]};
        end
        lfsr_next = s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx  <= '0;
            walk <= DATA_W'(1);
            lfsr <= PrbsSeed;
        end else if (load) begin
            idx  <= '0;
            walk <= DATA_W'(1);
            lfsr <= PrbsSeed;
        end else if (restart) begin
            idx  <= '0;
            walk <= DATA_W'(1);
        end else if (advance) begin
            idx  <= idx + 16'd1;
            // Rotating register gives 1 << (idx mod DATA_W) without a modulo.
            walk <= {walk[DATA_W-2:0], walk[DATA_W-1]};
            lfsr <= lfsr_next;
        end
    end

    always_comb begin
        data = '0;
        unique case (mode)
            ModeInc:  data = DATA_W'(idx);
            ModePrbs: data = prbs_word;
            ModeWalk: data = walk;
            ModeInv:  data = ~DATA_W'(idx);
            default:  data = '0;
        endcase
    end

endmodule

// File: rtl/ddr2_traffic_checker.sv
// DDR2 self-test traffic generator and checker on the user FIFO ports.
// Writes NUM_WORDS pattern words, idles GAP_CYC cycles, reads them back and
// compares against a regenerated pattern, repeating for 'loops' passes.
// Ports:
//   clk, rst                 clock / asynchronous active-high reset
//   start, mode, loops       run control (loops = 0 runs until start again)
//   init_done                DDR2 calibration done; dropping it aborts a run
//   wr_full, wr_en, wr_data  write FIFO side
//   rd_empty, rd_en, rd_data read FIFO side, rd_data valid RD_LAT after rd_en
//   busy, done, pass         run status
//   err_cnt                  saturating mismatch count
//   first_err_idx/_data      index and read data of the first mismatch
module ddr2_traffic_checker
    import ddr2_tc_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_WORDS = 1024,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned GAP_CYC   = 256,
    parameter int unsigned ERR_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [7:0]        loops,
    input  logic              init_done,
    input  logic              wr_full,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    input  logic              rd_empty,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [15:0]       first_err_idx,
    output logic [DATA_W-1:0] first_err_data
);

    localparam logic [15:0] LastIdx = 16'(NUM_WORDS - 1);

    tc_state_e         state;
    logic [1:0]        run_mode;
    logic [15:0]       wr_cnt;
    logic [15:0]       rd_cnt;
    logic [31:0]       gap_cnt;
    logic [7:0]        loop_cnt;
    logic              stop;
    logic [DATA_W-1:0] wr_pat;
    logic [DATA_W-1:0] exp_pat;

    // Compare pipeline: valid, expected word and word index travel together.
    logic [RD_LAT-1:0] vld_sr;
    logic [DATA_W-1:0] exp_sr [RD_LAT];
    logic [15:0]       idx_sr [RD_LAT];

    logic running, run_start, abort, push, pop;
    logic gap_done, drain_done, last_pass, cmp_err;

    always_comb begin
        running    = state inside {StWrite, StGap, StRead, StDrain};
        run_start  = (state == StIdle) && start && init_done;
        abort      = running && !init_done;
        push       = (state == StWrite) && !wr_full && init_done;
        pop        = (state == StRead) && !rd_empty && init_done;
        gap_done   = (state == StGap) && (gap_cnt + 32'd1 >= GAP_CYC);
        drain_done = (state == StDrain) && (vld_sr == '0);
        // A stop request arriving in the final drain cycle still counts.
        last_pass  = stop || (start && (loops == 8'd0)) ||
                     ((loops != 8'd0) && (loop_cnt + 8'd1 == loops));
        cmp_err    = vld_sr[RD_LAT-1] && (rd_data != exp_sr[RD_LAT-1]);
    end

    assign wr_en   = push;
    assign rd_en   = pop;
    assign wr_data = (state == StWrite) ? wr_pat : '0;

    ddr2_pat_gen #(.DATA_W(DATA_W)) u_wr_gen (
        .clk     (clk),
        .rst     (rst),
        .mode    (run_mode),
        .load    (run_start),
        .restart (drain_done && !last_pass),
        .advance (push),
        .data    (wr_pat)
    );

    // Advances once per pop, so at each read pass it holds the LFSR state the
    // write generator had at the start of that pass.
    ddr2_pat_gen #(.DATA_W(DATA_W)) u_exp_gen (
        .clk     (clk),
        .rst     (rst),
        .mode    (run_mode),
        .load    (run_start),
        .restart (gap_done),
        .advance (pop),
        .data    (exp_pat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sr <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                exp_sr[k] <= '0;
                idx_sr[k] <= '0;
            end
        end else begin
            vld_sr[0] <= pop;
            exp_sr[0] <= exp_pat;
            idx_sr[0] <= rd_cnt;
            for (int k = 1; k < RD_LAT; k++) begin
                vld_sr[k] <= vld_sr[k-1];
                exp_sr[k] <= exp_sr[k-1];
                idx_sr[k] <= idx_sr[k-1];
            end
            if (abort) vld_sr <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= StIdle;
            run_mode       <= ModeInc;
            wr_cnt         <= '0;
            rd_cnt         <= '0;
            gap_cnt        <= '0;
            loop_cnt       <= '0;
            stop           <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
        end else begin
            if (cmp_err && !abort) begin
                if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
                if (err_cnt == '0) begin
                    first_err_idx  <= idx_sr[RD_LAT-1];
                    first_err_data <= rd_data;
                end
            end
            if (running && start && (loops == 8'd0)) stop <= 1'b1;

            unique case (state)
                StIdle: begin
                    if (run_start) begin
                        state          <= StWrite;
                        run_mode       <= mode;
                        wr_cnt         <= '0;
                        loop_cnt       <= '0;
                        stop           <= 1'b0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_cnt        <= '0;
                        first_err_idx  <= '0;
                        first_err_data <= '0;
                    end
                end
                StWrite: begin
                    if (push) begin
                        if (wr_cnt == LastIdx) begin
                            state  <= StGap;
                            wr_cnt <= '0;
                        end else begin
                            wr_cnt <= wr_cnt + 16'd1;
                        end
                    end
                end
                StGap: begin
                    if (gap_done) begin
                        state   <= StRead;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 32'd1;
                    end
                end
                StRead: begin
                    if (pop) begin
                        if (rd_cnt == LastIdx) begin
                            state  <= StDrain;
                            rd_cnt <= '0;
                        end else begin
                            rd_cnt <= rd_cnt + 16'd1;
                        end
                    end
                end
                StDrain: begin
                    if (drain_done) begin
                        loop_cnt <= loop_cnt + 8'd1;
                        if (last_pass) begin
                            state <= StDone;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_cnt == '0);
                        end else begin
                            state <= StWrite;
                        end
                    end
                end
                StDone:  state <= StIdle;
                default: state <= StIdle;
            endcase

            if (abort) begin
                state   <= StDone;
                busy    <= 1'b0;
                done    <= 1'b1;
                pass    <= 1'b0;
                wr_cnt  <= '0;
                rd_cnt  <= '0;
                gap_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ddr2_traffic_checker.sv
// Bench for ddr2_traffic_checker: FIFO loopback memory model with optional
// stalls and bit-0 corruption, write-data scoreboard and directed runs.
module tb_ddr2_traffic_checker;

    localparam int DATA_W    = 32;
    localparam int NUM_WORDS = 40;
    localparam int RD_LAT    = 2;
    localparam int GAP_CYC   = 8;
    localparam int ERR_W     = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [1:0]        mode;
    logic [7:0]        loops;
    logic              init_done;
    logic              wr_full;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_empty;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ERR_W-1:0]  err_cnt;
    logic [15:0]       first_err_idx;
    logic [DATA_W-1:0] first_err_data;

    ddr2_traffic_checker #(
        .DATA_W    (DATA_W),
        .NUM_WORDS (NUM_WORDS),
        .RD_LAT    (RD_LAT),
        .GAP_CYC   (GAP_CYC),
        .ERR_W     (ERR_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .mode           (mode),
        .loops          (loops),
        .init_done      (init_done),
        .wr_full        (wr_full),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .rd_empty       (rd_empty),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .first_err_idx  (first_err_idx),
        .first_err_data (first_err_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory model and scoreboard state.
    logic [DATA_W-1:0] mem_q [$];
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];
    logic [30:0]       ref_lfsr;
    logic [DATA_W-1:0] word33;
    bit                stall_en    = 1'b0;
    bit                corrupt_all = 1'b0;
    int                corrupt_word = -1;
    int                cyc = 0, run_push = 0, run_pop = 0, last_push_cyc = 0, gap_meas = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        mem_q.delete();
        exp_q.delete();
        run_push = 0;
        run_pop  = 0;
        ref_lfsr = 31'h1;
        word33   = '0;
    endtask

    // Reference patterns; PRBS continues from ref_lfsr across calls.
    task automatic push_exp(input int m, input int nwords);
        logic [DATA_W-1:0] w;
        int idx;
        for (int i = 0; i < nwords; i++) begin
            idx = i % NUM_WORDS;
            w   = '0;
            case (m)
                0: w = DATA_W'(idx);
                1: begin
                    for (int b = 0; b < DATA_W; b++) begin
                        w[b]     = ref_lfsr[30] ^ ref_lfsr[27];
                        ref_lfsr = {ref_lfsr[29:0], w[b]};
                    end
                end
                2: w = DATA_W'(1) << (idx % DATA_W);
                default: w = ~DATA_W'(idx);
            endcase
            exp_q.push_back(w);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(done), 64'd1);
    endtask

    task automatic wait_count(input string tag, input bit pops, input int target);
        int n = 0;
        while (((pops ? run_pop : run_push) < target) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'((pops ? run_pop : run_push) >= target), 64'd1);
    endtask

    // Environment: stalls, loopback memory, write scoreboard, read latency.
    initial begin : env
        logic              we, re;
        logic [DATA_W-1:0] wd, nw;
        int                widx;
        wr_full  = 1'b0;
        rd_empty = 1'b0;
        rd_data  = '0;
        for (int k = 0; k < RD_LAT; k++) rd_pipe[k] = '0;
        forever begin
            @(negedge clk);
            wr_full  = stall_en && ($urandom_range(0, 99) < 30);
            rd_empty = (mem_q.size() == 0) || (stall_en && ($urandom_range(0, 99) < 30));
            #4;
            we = wr_en;
            wd = wr_data;
            re = rd_en;
            @(posedge clk);
            #1;
            cyc++;
            if (we) begin
                widx = run_push % NUM_WORDS;
                run_push++;
                last_push_cyc = cyc;
                if (widx == 33) word33 = wd;
                chk("push_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) chk("wr_data", 64'(wd), 64'(exp_q.pop_front()));
                mem_q.push_back((corrupt_all || widx == corrupt_word) ? (wd ^ DATA_W'(1)) : wd);
            end
            nw = '0;
            if (re) begin
                if (run_pop == 0) gap_meas = cyc - last_push_cyc;
                run_pop++;
                chk("pop_nonempty", 64'(mem_q.size() != 0), 64'd1);
                if (mem_q.size() != 0) nw = mem_q.pop_front();
            end
            for (int k = RD_LAT - 1; k > 0; k--) rd_pipe[k] = rd_pipe[k-1];
            rd_pipe[0] = nw;
            rd_data    = rd_pipe[RD_LAT-1];
        end
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        mode      = 2'd0;
        loops     = 8'd1;
        init_done = 1'b1;
        clear_model();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state.
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_pass", 64'(pass), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("rst_first_err_idx", 64'(first_err_idx), 64'd0);
        chk("rst_first_err_data", 64'(first_err_data), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_rd_en", 64'(rd_en), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);

        // Increment pattern, ideal FIFO, one pass.
        clear_model();
        push_exp(0, NUM_WORDS);
        mode = 2'd0; loops = 8'd1;
        pulse_start();
        chk("inc_busy", 64'(busy), 64'd1);
        wait_done("inc_done");
        chk("inc_pass", 64'(pass), 64'd1);
        chk("inc_err_cnt", 64'(err_cnt), 64'd0);
        chk("inc_pushes", 64'(run_push), 64'(NUM_WORDS));
        chk("inc_pops", 64'(run_pop), 64'(NUM_WORDS));
        chk("inc_gap", 64'(gap_meas), 64'(GAP_CYC + 1));
        chk("inc_scoreboard_empty", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        chk("inc_done_held", 64'(done), 64'd1);
        chk("inc_idle_busy", 64'(busy), 64'd0);

        // Word 5 bit 0 corrupted.
        clear_model();
        push_exp(0, NUM_WORDS);
        corrupt_word = 5;
        pulse_start();
        wait_done("c5_done");
        chk("c5_err_cnt", 64'(err_cnt), 64'd1);
        chk("c5_first_err_idx", 64'(first_err_idx), 64'd5);
        chk("c5_first_err_data", 64'(first_err_data), 64'h4);
        chk("c5_pass", 64'(pass), 64'd0);
        corrupt_word = -1;

        // PRBS, three passes, random stalls on both FIFOs.
        clear_model();
        push_exp(1, 3 * NUM_WORDS);
        stall_en = 1'b1;
        mode = 2'd1; loops = 8'd3;
        pulse_start();
        wait_done("prbs_done");
        chk("prbs_pushes", 64'(run_push), 64'(3 * NUM_WORDS));
        chk("prbs_pops", 64'(run_pop), 64'(3 * NUM_WORDS));
        chk("prbs_pass", 64'(pass), 64'd1);
        chk("prbs_err_cnt", 64'(err_cnt), 64'd0);
        stall_en = 1'b0;

        // Walking one, every word corrupted: error counter saturates.
        clear_model();
        push_exp(2, NUM_WORDS);
        corrupt_all = 1'b1;
        mode = 2'd2; loops = 8'd1;
        pulse_start();
        wait_done("walk_done");
        chk("walk_word33", 64'(word33), 64'h2);
        chk("walk_err_sat", 64'(err_cnt), 64'hf);
        chk("walk_first_err_idx", 64'(first_err_idx), 64'd0);
        chk("walk_first_err_data", 64'(first_err_data), 64'h0);
        chk("walk_pass", 64'(pass), 64'd0);

        // Reset in the middle of the read pass (errors already counted).
        clear_model();
        push_exp(0, NUM_WORDS);
        mode = 2'd0;
        pulse_start();
        wait_count("rstmid_reach_read", 1'b1, 10);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_rd_en", 64'(rd_en), 64'd0);
        chk("rstmid_wr_en", 64'(wr_en), 64'd0);
        chk("rstmid_err_cnt", 64'(err_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int p0, q0;
            p0 = run_pop;
            q0 = run_push;
            repeat (6) @(negedge clk);
            chk("rstmid_no_pops", 64'(run_pop), 64'(p0));
            chk("rstmid_no_pushes", 64'(run_push), 64'(q0));
        end
        corrupt_all = 1'b0;

        // Calibration lost mid-write: abort with pass=0.
        clear_model();
        push_exp(0, NUM_WORDS);
        pulse_start();
        wait_count("abort_reach_write", 1'b0, 10);
        @(negedge clk);
        init_done = 1'b0;
        wait_done("abort_done");
        chk("abort_pass", 64'(pass), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_err_cnt", 64'(err_cnt), 64'd0);
        chk("abort_no_reads", 64'(run_pop), 64'd0);
        @(negedge clk);
        init_done = 1'b1;

        // Endless run stopped by a start pulse during pass 2.
        clear_model();
        push_exp(0, 2 * NUM_WORDS);
        loops = 8'd0;
        pulse_start();
        wait_count("endless_reach_pass2", 1'b0, NUM_WORDS + 5);
        pulse_start();
        wait_done("endless_done");
        chk("endless_pushes", 64'(run_push), 64'(2 * NUM_WORDS));
        chk("endless_pops", 64'(run_pop), 64'(2 * NUM_WORDS));
        chk("endless_pass", 64'(pass), 64'd1);
        repeat (2 * GAP_CYC) @(negedge clk);
        chk("endless_idle_busy", 64'(busy), 64'd0);
        chk("endless_no_third_pass", 64'(run_push), 64'(2 * NUM_WORDS));

        // Start without calibration is ignored.
        clear_model();
        init_done = 1'b0;
        loops = 8'd1;
        pulse_start();
        repeat (5) @(negedge clk);
        chk("nocal_busy", 64'(busy), 64'd0);
        chk("nocal_no_pushes", 64'(run_push), 64'd0);
        chk("nocal_done_held", 64'(done), 64'd1);
        init_done = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
